mem_loader: RTL and testbench
=============================

# mem_loader

Byte-stream program loader that acts as the writing master on the data port of the CPU's 256×16 dual-port RAM. It receives a framed byte stream (valid/ready), assembles big-endian 16-bit words, writes them at consecutive addresses and checks a trailing checksum. While loading it holds the CPU in reset, so RAM contents can be replaced at run time instead of being hardcoded.

## Interface
Parameters:
- ADDR_W, 8, RAM word-address width; the RAM depth is 2^ADDR_W.
- TIMEOUT, 1024, maximum idle cycles between accepted bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that arms the loader; ignored while busy.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  RAM data-port write enable.
- mem_addr  out  ADDR_W  RAM data-port address.
- mem_wdata  out  16  RAM data-port write data.
- cpu_hold  out  1  holds the CPU in reset while high.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse at the end of a frame, on success or failure.
- err  out  1  sticky error flag for the last frame; cleared by the next accepted start.

## Operation
- Frame format: ADDR byte, CNT byte (N words; 0 means 256), then 2N data bytes (high byte first), then CSUM byte.
- The frame is good when the 8-bit sum of all frame bytes, CSUM included, is 0x00.
- A byte is accepted on a rising edge where in_valid and in_ready are both high.
- FSM states: IDLE, HDR_ADDR, HDR_CNT, DATA_HI, DATA_LO, WRITE, CSUM.
  - IDLE → HDR_ADDR on start. On that transition: clear err, set busy and cpu_hold high, clear the running sum.
  - HDR_ADDR → HDR_CNT: load the address register.
  - HDR_CNT → DATA_HI: load the word counter.
  - DATA_HI → DATA_LO: latch the high byte.
  - DATA_LO → WRITE: latch the low byte.
  - WRITE lasts 1 cycle with mem_we=1. Then go to DATA_HI if words remain, else CSUM. Increment the address modulo 2^ADDR_W.
  - CSUM → IDLE: set err if the sum is nonzero, and pulse done.
- in_ready is 1 in HDR_ADDR, HDR_CNT, DATA_HI, DATA_LO and CSUM. It is 0 in IDLE and WRITE.
- Every accepted byte is added to the running sum modulo 256.
- Words are written as they arrive. A checksum failure sets err but does not undo those writes.
- Timeout: a counter is cleared on each accepted byte and on entry to WRITE, and counts in the receiving states. When it reaches TIMEOUT the FSM goes to IDLE, err=1, and done pulses.
- The address wraps from 0xFF to 0x00 with no error.
- start while busy is ignored. in_valid in IDLE is ignored and no byte is consumed.

## Timing
- Reset value of every output is 0, including mem_addr and mem_wdata. The FSM resets to IDLE.
- Reset mid-frame aborts the frame immediately: mem_we and cpu_hold go to 0 asynchronously, and no done pulse is generated.
- All outputs are registered.
- Write latency: mem_we is high for exactly one cycle, the cycle after the low byte is accepted. mem_addr and mem_wdata are valid in that same cycle, and the RAM captures them at the end of that cycle.
- Peak throughput is 1 word per 3 cycles.
- done goes high the cycle after the CSUM byte is accepted (or the timeout fires). cpu_hold and busy fall in that same cycle. err is valid by then.
- start in the same cycle done is high is accepted, because the FSM is in IDLE.

## Structure
- Shared header (cpu_defs.vh) holds:
  - the state encodings;
  - the RAM geometry constants (ADDR_W=8, word width 16);
  - the checksum-good constant 0x00.
- One sub-module, loader_timeout: a clearable idle counter with enable, parameter TIMEOUT, and a one-cycle expired output.
- All other logic is the FSM plus datapath registers in mem_loader.

## Test plan
- Good frame 00 02 10 05 30 03 B6 → one-cycle writes 0x00=0x1005 and 0x01=0x3003; done pulse; err=0; cpu_hold high from the cycle after start until done.
- Wrap frame FF 02 12 34 56 78 EB → writes 0xFF=0x1234 then 0x00=0x5678; err=0.
- Bad checksum (previous frame with CSUM 0xEC) → both writes still occur; done pulse; err=1; next start clears err.
- Timeout with TIMEOUT=16 → stop after 00 01 10; after 16 idle cycles: IDLE, err=1, done pulse, no mem_we.
- Backpressure and stalls → random in_valid gaps; in_valid held high through WRITE consumes no extra byte; start pulsed mid-frame is ignored.
- Reset mid-frame → assert rst during DATA_LO; all outputs 0 at once, no done; a following good frame loads correctly.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding,
// RAM geometry and the checksum value that marks a good frame.
package mem_loader_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 16;

  // Sum of every frame byte (CSUM included), modulo 256, for a good frame.
  localparam logic [7:0] CSUM_GOOD = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR_ADDR = 3'd1,
    S_HDR_CNT  = 3'd2,
    S_DATA_HI  = 3'd3,
    S_DATA_LO  = 3'd4,
    S_WRITE    = 3'd5,
    S_CSUM     = 3'd6
  } state_t;

endpackage

// File: rtl/mem_loader_timeout.sv
// Idle counter for the loader. It counts cycles while enabled and is
// cleared when disabled or when clr_i is high. expired_o is high for the
// cycle whose edge would bring the count to TIMEOUT; TIMEOUT = 0 disables it.
module loader_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart whenever a byte is taken or the loader is not receiving.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (TIMEOUT != 0) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_loader.sv
// Byte-stream program loader. Receives ADDR, CNT, 2*N data bytes (high byte
// first) and CSUM over a valid/ready stream, writes each 16-bit word to the
// RAM data port as soon as it is complete, and holds the CPU in reset while a
// frame is in progress.
//
// Handshake: a byte is consumed on a rising edge where in_valid and in_ready
// are both high; in_ready is registered and depends only on the FSM state, so
// in_valid may be held high at any time without a byte being taken in IDLE or
// WRITE.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [RAM_DATA_W-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  state_t                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [8:0]              words_q;
  logic [7:0]              hi_q;
  logic [7:0]              sum_q;
  logic [RAM_DATA_W-1:0]   wdata_q;
  logic                    in_ready_q;
  logic                    we_q;
  logic                    hold_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic                    accept;
  logic [7:0]              sum_d;
  logic                    tmo_expired;

  assign accept = in_valid && in_ready_q;
  assign sum_d  = sum_q + in_data;

  // in_ready_q is high exactly in the receiving states, so it doubles as the
  // idle-counter enable.
  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .en_i      (in_ready_q),
    .clr_i     (accept),
    .expired_o (tmo_expired)
  );

  // Frame FSM with its datapath registers; every output is a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      words_q    <= '0;
      hi_q       <= '0;
      sum_q      <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (accept) begin
        sum_q <= sum_d;
      end
      if (tmo_expired) begin
        state_q    <= S_IDLE;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b0;
        hold_q     <= 1'b0;
        err_q      <= 1'b1;
        done_q     <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q    <= S_HDR_ADDR;
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              hold_q     <= 1'b1;
              sum_q      <= 8'h00;
              in_ready_q <= 1'b1;
            end
          end
          S_HDR_ADDR: begin
            if (accept) begin
              addr_q  <= ADDR_W'(in_data);
              state_q <= S_HDR_CNT;
            end
          end
          S_HDR_CNT: begin
            if (accept) begin
              // A count byte of zero stands for a full 256-word image.
              words_q <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
              state_q <= S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            if (accept) begin
              hi_q    <= in_data;
              state_q <= S_DATA_LO;
            end
          end
          S_DATA_LO: begin
            if (accept) begin
              wdata_q    <= {hi_q, in_data};
              we_q       <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= S_WRITE;
            end
          end
          S_WRITE: begin
            // The RAM captures addr/wdata at the end of this cycle.
            addr_q     <= addr_q + ADDR_W'(1);
            words_q    <= words_q - 9'd1;
            in_ready_q <= 1'b1;
            state_q    <= (words_q == 9'd1) ? S_CSUM : S_DATA_HI;
          end
          S_CSUM: begin
            if (accept) begin
              err_q      <= (sum_d != CSUM_GOOD);
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              hold_q     <= 1'b0;
              in_ready_q <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            hold_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: directed frame table, randomized frames against a
// frame-level reference model, timeout and mid-frame reset sequences.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  logic [23:0] exp_q[$];
  logic [23:0] exp_w;
  logic [7:0]  frame_q[$];

  typedef struct {
    int          len;
    logic [7:0]  b [8];
    logic        exp_err;
    logic [23:0] w0;
    logic [23:0] w1;
  } vec_t;

  vec_t tbl[3];

  mem_loader #(
    .ADDR_W  (8),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got hang required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_cnt++;
      if (done) done_cnt++;
      checks++;
      if (cpu_hold !== busy) begin
        errors++;
        $display("FAIL hold_vs_busy: cpu_hold=%0b required busy=%0b", cpu_hold, busy);
      end
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h required no write", mem_addr, mem_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== exp_w) begin
            errors++;
            $display("FAIL write: got %0h required %0h", {mem_addr, mem_wdata}, exp_w);
          end
        end
      end
    end
  end

  // Reference model: expected writes and error flag from the frame bytes.
  task automatic model_frame(output logic exp_err);
    int s;
    int a;
    int n;
    s = 0;
    foreach (frame_q[i]) s += int'(frame_q[i]);
    exp_err = ((s % 256) != 0);
    a = int'(frame_q[0]);
    n = (frame_q[1] == 8'h00) ? 256 : int'(frame_q[1]);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({8'((a + k) % 256), frame_q[2 + 2 * k], frame_q[3 + 2 * k]});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte (after an optional gap) and return once it is consumed.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    int budget;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: in_ready stayed 0 for %0d cycles, required <50", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic exp_err, input int max_gap, input bit inject);
    int acc0;
    int inj_at;
    acc0 = acc_cnt;
    pulse_start();
    check("busy_after_start", busy, 1);
    check("hold_after_start", cpu_hold, 1);
    check("err_cleared_on_start", err, 0);
    check("done_one_cycle", done, 0);
    inj_at = inject ? int'($urandom_range(1, frame_q.size() - 1)) : -1;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == inj_at) begin
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
      end
      send_byte(frame_q[i], max_gap);
    end
    in_valid = 1'b0;
    check("done_after_csum", done, 1);
    check("busy_low_at_done", busy, 0);
    check("hold_low_at_done", cpu_hold, 0);
    check("err_at_done", err, exp_err);
    check("bytes_consumed", acc_cnt - acc0, frame_q.size());
    check("writes_pending", exp_q.size(), 0);
  endtask

  task automatic build_random(input logic [7:0] addr, input logic [7:0] cnt, input bit bad);
    int n;
    logic [7:0] s;
    frame_q.delete();
    frame_q.push_back(addr);
    frame_q.push_back(cnt);
    n = (cnt == 8'h00) ? 256 : int'(cnt);
    for (int i = 0; i < 2 * n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    s = 8'h00;
    foreach (frame_q[i]) s = s + frame_q[i];
    s = 8'h00 - s;
    if (bad) s = s + 8'($urandom_range(1, 255));
    frame_q.push_back(s);
  endtask

  initial begin
    logic e;
    int   n;
    int   d0;

    tbl[0] = '{len: 7, b: '{8'h00, 8'h02, 8'h10, 8'h05, 8'h30, 8'h03, 8'hB6, 8'h00},
               exp_err: 1'b0, w0: 24'h00_1005, w1: 24'h01_3003};
    tbl[1] = '{len: 7, b: '{8'hFF, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEB, 8'h00},
               exp_err: 1'b0, w0: 24'hFF_1234, w1: 24'h00_5678};
    tbl[2] = '{len: 7, b: '{8'h00, 8'h02, 8'h10, 8'h05, 8'h30, 8'h03, 8'hEC, 8'h00},
               exp_err: 1'b1, w0: 24'h00_1005, w1: 24'h01_3003};

    // Reset block.
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    // in_valid in IDLE consumes nothing.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_no_consume", acc_cnt, 0);
    check("idle_stays", dbg_state, S_IDLE);

    // Directed table, back to back (start lands in the done cycle).
    for (int t = 0; t < 3; t++) begin
      frame_q.delete();
      for (int j = 0; j < tbl[t].len; j++) frame_q.push_back(tbl[t].b[j]);
      exp_q.push_back(tbl[t].w0);
      exp_q.push_back(tbl[t].w1);
      run_frame(tbl[t].exp_err, 0, 1'b0);
    end

    // Timeout: frame stops after 00 01 10.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    in_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_idle_cycles", n, TMO);
    check("timeout_err", err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_hold", cpu_hold, 0);
    check("timeout_state", dbg_state, S_IDLE);
    check("timeout_in_ready", in_ready, 0);

    // Randomized frames with gaps and ignored mid-frame starts.
    for (int f = 0; f < 20; f++) begin
      logic [7:0] a;
      logic [7:0] c;
      a = (f == 7) ? 8'hFD : 8'($urandom_range(0, 255));
      c = (f == 5) ? 8'h00 : 8'($urandom_range(1, 6));
      build_random(a, c, ($urandom_range(0, 3) == 0));
      model_frame(e);
      run_frame(e, int'($urandom_range(0, 3)), (f % 3 == 0));
    end

    // Reset in DATA_LO aborts the frame at once.
    pulse_start();
    send_byte(8'h37, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    in_valid = 1'b0;
    check("pre_rst_state", dbg_state, S_DATA_LO);
    check("pre_rst_addr", mem_addr, 8'h37);
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_cpu_hold", cpu_hold, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_state", dbg_state, S_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt, d0);

    frame_q.delete();
    for (int j = 0; j < tbl[0].len; j++) frame_q.push_back(tbl[0].b[j]);
    model_frame(e);
    run_frame(e, 2, 1'b0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
